emu_clk_en_gen: RTL and testbench



---
 rtl/emu_clk_en_gen_pkg.sv | 22 ++
 rtl/emu_clk_div_ch.sv | 50 +++++
 rtl/emu_clk_en_gen.sv | 134 +++++++++++++
 tb/tb_emu_clk_en_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emu_clk_en_gen_pkg.sv
// Shared types and default constants for the emulator clock-enable generator.
package emu_clk_en_gen_pkg;

  localparam int unsigned N_CH_DEF       = 4;
  localparam int unsigned DIV_WIDTH_DEF  = 16;
  localparam int unsigned STEP_WIDTH_DEF = 16;
  localparam int unsigned RST_CYCLES_DEF = 8;
  localparam int unsigned CYCLE_CNT_W    = 64;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } state_e;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/emu_clk_div_ch.sv
// One clock-enable channel: period counter, shadow divide ratio, clk_en pulse and gated clock value.
module emu_clk_div_ch
  import emu_clk_en_gen_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic                 active,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] ratio,
  output logic                 clk_en,
  output logic                 clk_val
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] shadow_q;
  logic [DIV_WIDTH-1:0] last_c;
  logic                 adv_c;
  logic                 wrap_c;

  // A zero ratio behaves as divide-by-one, so its last count is also zero.
  always_comb begin
    last_c = (shadow_q == '0) ? '0 : shadow_q - DIV_WIDTH'(1);
    adv_c  = active & en;
    wrap_c = adv_c & (cnt_q == last_c);
  end

  // The shadow ratio only reloads at a period boundary or while the generator is stopped.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      clk_en   <= 1'b0;
      clk_val  <= 1'b0;
    end else begin
      clk_en <= wrap_c;
      if (wrap_c) begin
        cnt_q   <= '0;
        clk_val <= ~clk_val;
      end else if (adv_c) begin
        cnt_q <= cnt_q + DIV_WIDTH'(1);
      end
      if (wrap_c || !active) begin
        shadow_q <= ratio;
      end
    end
  end

endmodule

// File: rtl/emu_clk_en_gen.sv
// N-channel emulator clock-enable generator with run/stop/single-step control and stretched reset.
// Optional emulated-time counter output enabled by EMU_CLK_EN_GEN_CYCLE_CNT_EN.
module emu_clk_en_gen
  import emu_clk_en_gen_pkg::*;
#(
  parameter int unsigned N_CH       = N_CH_DEF,
  parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int unsigned STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst,
  input  logic                      run,
  input  logic                      step_req,
  input  logic [STEP_WIDTH-1:0]     step_len,
  input  logic [N_CH-1:0]           ch_en,
  input  logic [N_CH*DIV_WIDTH-1:0] div_ratio,
  output logic [N_CH-1:0]           clk_en,
  output logic [N_CH-1:0]           clk_val,
  output logic                      rst_out,
  output logic                      busy,
  output logic                      step_done
`ifdef EMU_CLK_EN_GEN_CYCLE_CNT_EN
  ,
  output logic [CYCLE_CNT_W-1:0]    cycle_cnt
`endif
);

  localparam int unsigned HOLD_W = clog2_min1(RST_CYCLES);

  state_e                state_q;
  state_e                state_d;
  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [HOLD_W-1:0]     hold_cnt_d;
  logic [STEP_WIDTH-1:0] step_cnt_q;
  logic [STEP_WIDTH-1:0] step_cnt_d;
  logic                  rst_out_d;
  logic                  busy_d;
  logic                  step_done_d;
  logic                  active_c;

  // A STEP cycle with nothing left to count is the terminal cycle, not an active one.
  always_comb begin
    active_c = (state_q == RUN) || ((state_q == STEP) && (step_cnt_q != '0));
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    step_cnt_d  = step_cnt_q;
    step_done_d = 1'b0;
    case (state_q)
      HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      IDLE: begin
        if (step_req) begin
          state_d    = STEP;
          step_cnt_d = step_len;
        end else if (run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (step_cnt_q == '0) begin
          state_d     = IDLE;
          step_done_d = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q - STEP_WIDTH'(1);
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
    rst_out_d = (state_d == HOLD);
    busy_d    = (state_d == RUN) || (state_d == STEP);
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      step_cnt_q <= '0;
      rst_out    <= 1'b1;
      busy       <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      step_cnt_q <= step_cnt_d;
      rst_out    <= rst_out_d;
      busy       <= busy_d;
      step_done  <= step_done_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    emu_clk_div_ch #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_ch (
      .emu_clk (emu_clk),
      .emu_rst (emu_rst),
      .active  (active_c),
      .en      (ch_en[i]),
      .ratio   (div_ratio[i*DIV_WIDTH +: DIV_WIDTH]),
      .clk_en  (clk_en[i]),
      .clk_val (clk_val[i])
    );
  end

`ifdef EMU_CLK_EN_GEN_CYCLE_CNT_EN
  // Emulated time: one tick per active edge.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      cycle_cnt <= '0;
    end else if (active_c) begin
      cycle_cnt <= cycle_cnt + CYCLE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_emu_clk_en_gen.sv
// Testbench for emu_clk_en_gen: directed tables and sequences plus randomized run against a reference model.
module tb_emu_clk_en_gen;

  localparam int unsigned N_CH = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned SW   = 16;
  localparam int unsigned RC   = 8;

  localparam int M_HOLD = 0;
  localparam int M_IDLE = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;

  logic                 emu_clk = 1'b0;
  logic                 emu_rst = 1'b1;
  logic                 run = 1'b0;
  logic                 step_req = 1'b0;
  logic [SW-1:0]        step_len = '0;
  logic [N_CH-1:0]      ch_en = '0;
  logic [N_CH*DW-1:0]   div_ratio = '0;
  logic [N_CH-1:0]      clk_en;
  logic [N_CH-1:0]      clk_val;
  logic                 rst_out;
  logic                 busy;
  logic                 step_done;
`ifdef EMU_CLK_EN_GEN_CYCLE_CNT_EN
  logic [63:0]          cycle_cnt;
`endif

  int errors = 0;
  int checks = 0;

  emu_clk_en_gen #(
    .N_CH       (N_CH),
    .DIV_WIDTH  (DW),
    .STEP_WIDTH (SW),
    .RST_CYCLES (RC)
  ) dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .run       (run),
    .step_req  (step_req),
    .step_len  (step_len),
    .ch_en     (ch_en),
    .div_ratio (div_ratio),
    .clk_en    (clk_en),
    .clk_val   (clk_val),
    .rst_out   (rst_out),
    .busy      (busy),
    .step_done (step_done)
`ifdef EMU_CLK_EN_GEN_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 emu_clk = ~emu_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge emu_clk);
    #1;
  endtask

  task automatic set_ratio(input int ch, input int unsigned r);
    div_ratio[ch*DW +: DW] = DW'(r);
  endtask

  // Reference model: countdown of active cycles remaining in each channel's period.
  int              m_mode;
  int              m_hold;
  int              m_step;
  int              m_remain [N_CH];
  logic [N_CH-1:0] m_en;
  logic [N_CH-1:0] m_val;
  logic            m_rst;
  logic            m_busy;
  logic            m_done;
  longint          m_cyc;

  function automatic int eff(input int ch);
    int r;
    r = int'(div_ratio[ch*DW +: DW]);
    return (r == 0) ? 1 : r;
  endfunction

  task automatic model_reset;
    m_mode = M_HOLD;
    m_hold = RC;
    m_step = 0;
    for (int c = 0; c < N_CH; c++) m_remain[c] = eff(c);
    m_en   = '0;
    m_val  = '0;
    m_rst  = 1'b1;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_cyc  = 0;
  endtask

  task automatic model_step;
    bit act;
    if (emu_rst) begin
      model_reset();
      return;
    end
    act = (m_mode == M_RUN) || (m_mode == M_STEP && m_step > 0);
    for (int c = 0; c < N_CH; c++) begin
      m_en[c] = 1'b0;
      if (act && ch_en[c]) begin
        m_remain[c]--;
        if (m_remain[c] == 0) begin
          m_en[c]     = 1'b1;
          m_val[c]    = ~m_val[c];
          m_remain[c] = eff(c);
        end
      end
    end
    if (act) m_cyc++;
    m_done = 1'b0;
    case (m_mode)
      M_HOLD: begin
        m_hold--;
        if (m_hold == 0) m_mode = M_IDLE;
      end
      M_IDLE: begin
        if (step_req) begin
          m_mode = M_STEP;
          m_step = int'(step_len);
        end else if (run) begin
          m_mode = M_RUN;
        end
      end
      M_RUN: if (!run) m_mode = M_IDLE;
      default: begin
        if (m_step == 0) begin
          m_mode = M_IDLE;
          m_done = 1'b1;
        end else begin
          m_step--;
        end
      end
    endcase
    m_rst  = (m_mode == M_HOLD);
    m_busy = (m_mode == M_RUN) || (m_mode == M_STEP);
  endtask

  // Pulse reset for one edge, then count how long rst_out stays high (bounded).
  task automatic do_reset(output int highs, output logic any_en, output logic any_busy);
    run      = 1'b0;
    step_req = 1'b0;
    emu_rst  = 1'b1;
    model_reset();
    tick();
    emu_rst  = 1'b0;
    highs    = 0;
    any_en   = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!rst_out) break;
      highs++;
      any_en   = any_en | (|clk_en);
      any_busy = any_busy | busy;
      model_step();
      tick();
    end
  endtask

  typedef struct {
    logic            run;
    logic [N_CH-1:0] exp_en;
    logic [N_CH-1:0] exp_val;
    logic            exp_busy;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int   highs;
    logic any_en;
    logic any_busy;
    int   pulses;
    int   dones;
    int   busy_n;
    int   done_at;
    logic [6:0] exp_seq;

    vecs[0] = '{1'b1, 4'b0000, 4'b0000, 1'b1};
    vecs[1] = '{1'b1, 4'b1001, 4'b1001, 1'b1};
    vecs[2] = '{1'b1, 4'b1011, 4'b0010, 1'b1};
    vecs[3] = '{1'b1, 4'b1101, 4'b1111, 1'b1};
    vecs[4] = '{1'b1, 4'b1011, 4'b0100, 1'b1};
    vecs[5] = '{1'b0, 4'b1001, 4'b1101, 1'b0};
    vecs[6] = '{1'b0, 4'b0000, 4'b1101, 1'b0};

    // Reset release and divide table with ratios {1,2,3,0}.
    set_ratio(0, 1); set_ratio(1, 2); set_ratio(2, 3); set_ratio(3, 0);
    ch_en = 4'b1111;
    tick();
    do_reset(highs, any_en, any_busy);
    check("rst_out_high_cycles", 64'(highs), 64'(RC));
    check("busy_during_hold", 64'(any_busy), 64'd0);
    check("clk_en_during_hold", 64'(any_en), 64'd0);

    // Zero-length step: terminates immediately with no enables.
    step_req = 1'b1; step_len = '0;
    tick();
    check("step0_busy", 64'(busy), 64'd1);
    step_req = 1'b0;
    tick();
    check("step0_done", 64'(step_done), 64'd1);
    check("step0_clk_en", 64'(clk_en), 64'd0);
    tick();
    check("step0_done_clear", 64'(step_done), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run = vecs[i].run;
      tick();
      check($sformatf("tbl%0d_clk_en", i), 64'(clk_en), 64'(vecs[i].exp_en));
      check($sformatf("tbl%0d_clk_val", i), 64'(clk_val), 64'(vecs[i].exp_val));
      check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
    end

    // Stop/resume on ch1 with ratio 5.
    set_ratio(1, 5);
    ch_en = 4'b0010;
    do_reset(highs, any_en, any_busy);
    pulses = 0;
    run = 1'b1;
    tick(); tick(); tick();
    pulses += int'(clk_en[1]);
    run = 1'b0;
    tick();
    pulses += int'(clk_en[1]);
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(clk_en[1]);
    end
    check("stop_no_pulses", 64'(pulses), 64'd0);
    run = 1'b1;
    tick();
    check("resume_r0", 64'(clk_en[1]), 64'd0);
    tick();
    check("resume_r1", 64'(clk_en[1]), 64'd0);
    tick();
    check("resume_r2_pulse", 64'(clk_en[1]), 64'd1);
    run = 1'b0;
    tick();

    // Step burst of 7 with ratio 3; run and step_req pressed during the burst.
    set_ratio(0, 3);
    ch_en = 4'b0001;
    do_reset(highs, any_en, any_busy);
    step_req = 1'b1; step_len = SW'(7);
    tick();
    check("step7_busy_entry", 64'(busy), 64'd1);
    pulses = 0; dones = 0; busy_n = 0; done_at = -1;
    run = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e > 8) run = 1'b0;
      step_req = (e <= 8) ? 1'(e % 2) : 1'b0;
      step_len = SW'(3);
      tick();
      pulses += int'(clk_en[0]);
      busy_n += int'(busy);
      if (step_done) begin
        dones++;
        done_at = e;
      end
    end
    check("step7_pulses", 64'(pulses), 64'd2);
    check("step7_done_count", 64'(dones), 64'd1);
    check("step7_done_pos", 64'(done_at), 64'd8);
    check("step7_busy_cycles", 64'(busy_n), 64'd7);

    // Ratio change 4 -> 2 with cnt at 1.
    set_ratio(0, 4);
    do_reset(highs, any_en, any_busy);
    run = 1'b1;
    tick(); tick();
    set_ratio(0, 2);
    exp_seq = 7'b1010100;
    for (int j = 0; j < 7; j++) begin
      tick();
      check($sformatf("ratio_chg_a%0d", j + 2), 64'(clk_en[0]), 64'(exp_seq[j]));
    end
    run = 1'b0;
    tick();

    // Reset asserted in the middle of a step burst.
    for (int c = 0; c < N_CH; c++) set_ratio(c, 1);
    ch_en = 4'b1111;
    do_reset(highs, any_en, any_busy);
    step_req = 1'b1; step_len = SW'(20);
    tick();
    step_req = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_clk_val", 64'(clk_val), 64'hF);
    emu_rst = 1'b1;
    tick();
    emu_rst = 1'b0;
    check("midrst_rst_out", 64'(rst_out), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_step_done", 64'(step_done), 64'd0);
    check("midrst_clk_en", 64'(clk_en), 64'd0);
    check("midrst_clk_val", 64'(clk_val), 64'd0);
`ifdef EMU_CLK_EN_GEN_CYCLE_CNT_EN
    check("midrst_cycle_cnt", cycle_cnt, 64'd0);
`endif
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      dones += int'(step_done);
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    check("midrst_idle_after", 64'(busy), 64'd0);

    // Randomized run against the reference model.
    for (int c = 0; c < N_CH; c++) set_ratio(c, $urandom_range(0, 6));
    ch_en = 4'(($urandom() & 32'hF));
    do_reset(highs, any_en, any_busy);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) run = ~run;
      step_req = ($urandom_range(0, 7) == 0);
      step_len = SW'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) ch_en = ch_en ^ 4'(1 << $urandom_range(0, N_CH - 1));
      emu_rst = ($urandom_range(0, 199) == 0);
      model_step();
      tick();
      check($sformatf("rand%0d", i), {52'd0, clk_en, clk_val, rst_out, busy, step_done, 1'b0},
            {52'd0, m_en, m_val, m_rst, m_busy, m_done, 1'b0});
`ifdef EMU_CLK_EN_GEN_CYCLE_CNT_EN
      check($sformatf("rand%0d_cyc", i), cycle_cnt, 64'(m_cyc));
`endif
    end
    emu_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
